// File: rtl/accel_profile_gen.sv
// Acceleration profile generator: fills a 4-deep FWFT FIFO with a ramp of step periods
// (start -> target -> start). Optional underflow flag under ACCEL_PROFILE_UNDERFLOW_EN.
module accel_profile_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] start_period,
    input  logic [31:0] target_period,
    input  logic [15:0] delta,
    input  logic        read,
    output logic [31:0] pul_value,
    output logic        empty,
    output logic        full,
    output logic [15:0] accel_len,
    output logic        len_valid,
    output logic        busy,
    output logic        gen_done,
`ifdef ACCEL_PROFILE_UNDERFLOW_EN
    output logic        underflow,
`endif
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCEL = 2'd1,
        S_DECEL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cur_q, cur_d;
    logic [31:0] sp_q, sp_d;
    logic [31:0] tgt_q, tgt_d;
    logic [15:0] d_q, d_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] alen_q, alen_d;
    logic        lv_q, lv_d;

    logic [31:0] mem_q [4];
    logic [1:0]  rd_ptr_q, wr_ptr_q;
    logic [2:0]  count_q;

    logic        start_ok, gen_ok, push, pop, flush;
    logic [31:0] sp_eff;
    logic [15:0] d_eff;
    logic [32:0] dec33, inc33, tinc33;
    logic [15:0] cnt_inc;

    assign start_ok = start && (state_q == S_IDLE || state_q == S_DONE);
    assign gen_ok   = (state_q == S_ACCEL || state_q == S_DECEL) && (count_q != 3'd4);
    assign sp_eff   = (start_period >= target_period) ? start_period : target_period;
    assign d_eff    = (delta == 16'd0) ? 16'd1 : delta;

    // 33-bit arithmetic so underflow/overflow is visible before clamping
    assign dec33    = {1'b0, cur_q} - {17'd0, d_q};
    assign inc33    = {1'b0, cur_q} + {17'd0, d_q};
    assign tinc33   = {1'b0, tgt_q} + {17'd0, d_q};
    assign cnt_inc  = (cnt_q == 16'hFFFF) ? 16'hFFFF : cnt_q + 16'd1;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        sp_d    = sp_q;
        tgt_d   = tgt_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        alen_d  = alen_q;
        lv_d    = lv_q;
        flush   = 1'b0;
        push    = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            flush   = 1'b1;
            lv_d    = 1'b0;
        end else if (start_ok) begin
            state_d = S_ACCEL;
            sp_d    = sp_eff;
            tgt_d   = target_period;
            d_d     = d_eff;
            cur_d   = sp_eff;
            cnt_d   = 16'd0;
            lv_d    = 1'b0;
            flush   = 1'b1;
        end else if (gen_ok) begin
            push = 1'b1;
            if (state_q == S_ACCEL) begin
                if (cur_q <= tgt_q) begin
                    alen_d = cnt_inc;
                    lv_d   = 1'b1;
                    if (tgt_q < sp_q) begin
                        state_d = S_DECEL;
                        cur_d   = (tinc33 >= {1'b0, sp_q}) ? sp_q : tinc33[31:0];
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cur_d = (dec33[32] || dec33 < {1'b0, tgt_q}) ? tgt_q : dec33[31:0];
                    cnt_d = cnt_inc;
                end
            end else begin
                if (cur_q >= sp_q) begin
                    state_d = S_DONE;
                end else begin
                    cur_d = (inc33 >= {1'b0, sp_q}) ? sp_q : inc33[31:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cur_q   <= 32'd0;
            sp_q    <= 32'd0;
            tgt_q   <= 32'd0;
            d_q     <= 16'd0;
            cnt_q   <= 16'd0;
            alen_q  <= 16'd0;
            lv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            sp_q    <= sp_d;
            tgt_q   <= tgt_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            alen_q  <= alen_d;
            lv_q    <= lv_d;
        end
    end

    assign pop = read && (count_q != 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= 2'd0;
            wr_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            for (int i = 0; i < 4; i++) mem_q[i] <= 32'd0;
        end else if (flush) begin
            rd_ptr_q <= 2'd0;
            wr_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= cur_q;
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_q + {2'd0, push} - {2'd0, pop};
        end
    end

`ifdef ACCEL_PROFILE_UNDERFLOW_EN
    logic uf_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 uf_q <= 1'b0;
        else if (abort || start_ok) uf_q <= 1'b0;
        else if (read && empty)     uf_q <= 1'b1;
    end
    assign underflow = uf_q;
`endif

    assign empty       = (count_q == 3'd0);
    assign full        = (count_q == 3'd4);
    assign pul_value   = empty ? 32'd0 : mem_q[rd_ptr_q];
    assign accel_len   = alen_q;
    assign len_valid   = lv_q;
    assign busy        = (state_q == S_ACCEL) || (state_q == S_DECEL);
    assign gen_done    = (state_q == S_DONE);
    assign dbg_state_o = state_q;

endmodule

// File: doc/accel_profile_gen.md
ACCEL_PROFILE_GEN -- requirements
Module: accel_profile_gen

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, all logic on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port: start  input  1  one-cycle request to latch config and begin generation.
REQ-004 SHALL have port: abort  input  1  one-cycle request to flush and return to IDLE.
REQ-005 SHALL have port: start_period  input  32  slowest period (clk cycles), sampled on accepted start.
REQ-006 SHALL have port: target_period  input  32  cruise period (clk cycles), sampled on accepted start.
REQ-007 SHALL have port: delta  input  16  period change per entry, sampled on accepted start.
REQ-008 SHALL have port: read  input  1  pop strobe from the downstream pulse controller.
REQ-009 SHALL have port: pul_value  output  32  head entry of the output FIFO (first-word fall-through).
REQ-010 SHALL have port: empty / full  output  1 each  FIFO status.
REQ-011 SHALL have port: accel_len  output  16  number of acceleration entries; valid when len_valid=1.
REQ-012 SHALL have port: len_valid / busy / gen_done  output  1 each  status levels.

Function
REQ-013 States: IDLE, ACCEL, DECEL, DONE; busy=1 in ACCEL|DECEL; gen_done=1 in DONE only.
REQ-014 start accepted only in IDLE or DONE; on accept: sp_eff=max(start_period,target_period), d_eff=(delta==0)?1:delta, cur=sp_eff, cnt=0, FIFO flushed, len_valid=0, state->ACCEL.
REQ-015 Internal FIFO: depth 4, 32-bit; pul_value shows head while empty=0; read pops head next edge; read while empty is ignored.
REQ-016 At most one push per cycle, only in ACCEL/DECEL and only when FIFO count<4 before the edge; push and pop in the same cycle both take effect.
REQ-017 ACCEL push: write cur; if cur<=target_period: accel_len=cnt+1 (saturate 16'hFFFF), len_valid=1, then DECEL with cur=min(target+d_eff, sp_eff) if target<sp_eff, else DONE; otherwise cur=max(cur-d_eff, target_period), cnt+1.
REQ-018 DECEL push: write cur; if cur>=sp_eff -> DONE; else cur=min(cur+d_eff, sp_eff).
REQ-019 All add/subtract done at 33 bits; no wrap-around; results clamped per REQ-017/018.
REQ-020 Latency: start sampled edge N -> first entry pushed edge N+1 -> empty=0 after edge N+1.
REQ-021 FIFO full: generation stalls, state and cur held, until a pop frees space.
REQ-022 abort in any state: next edge FIFO flushed (empty=1), len_valid=0, state IDLE; abort wins over simultaneous start.
REQ-023 start in ACCEL/DECEL ignored; DONE persists with FIFO contents intact until start or abort.

Reset
REQ-024 rst_n=0: state IDLE, FIFO empty (empty=1, full=0), pul_value=0, accel_len=0, len_valid=0, busy=0, gen_done=0, internal registers 0.
REQ-025 Reset mid-generation SHALL discard all entries; no push occurs until a new start after rst_n deasserts.

Configuration
REQ-026 Macro ACCEL_PROFILE_UNDERFLOW_EN: when defined, output port underflow (1 bit) SHALL exist, set sticky when read=1 while empty=1, cleared by reset, accepted start, or abort.
REQ-027 Without ACCEL_PROFILE_UNDERFLOW_EN the underflow port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-028 start_period=1000,target=400,delta=200, read on every non-empty cycle -> popped 1000,800,600,400,600,800,1000; accel_len=4; gen_done=1.
REQ-029 start_period=1000,target=450,delta=200 -> popped 1000,800,600,450,650,850,1000; accel_len=4.
REQ-030 start_period=300,target=500,delta=50 -> single entry 500; accel_len=1; DONE.
REQ-031 start_period=10,target=7,delta=0, no reads -> 10,9,8,7 fill FIFO, full=1, busy=1 stalled; one read -> next edge 8 pushed (count back to 4).
REQ-032 abort during ACCEL with 3 entries buffered -> next edge empty=1, busy=0, len_valid=0; a following start restarts cleanly from sp_eff.
REQ-033 With ACCEL_PROFILE_UNDERFLOW_EN: read while empty=1 -> underflow=1 next edge, holds until start.
